alu_mul_seq: RTL and testbench

Iterative RV32M multiply sequencer for the EX stage: it borrows the existing 32-bit EX-stage ALU for 64 cycles to compute MUL (low word) or MULHU (unsigned high word). Each bit uses one shift-and-add step: one ADD cycle, then one SLTU carry-recovery cycle. While busy, the block owns the ALU operand and function inputs through the EX operand mux, and hazard logic stalls the pipeline.

---
 rtl/alu_mul_seq_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 131 +++++++++++++
 tb/tb_alu_mul_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared parameters for the EX-stage multiply sequencer: ALU function codes,
// sequencer state encoding and op_sel encoding (also used by the hazard unit).
package alu_mul_seq_pkg;

  localparam logic [3:0] AluFuncAdd  = 4'b0000;
  localparam logic [3:0] AluFuncSltu = 4'b0011;

  localparam logic OpSelMul   = 1'b0;
  localparam logic OpSelMulhu = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAdd   = 2'd1,
    StCarry = 2'd2,
    StDone  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative RV32M MUL/MULHU sequencer that borrows the EX-stage ALU: one ADD cycle
// and one SLTU carry-recovery cycle per multiplier bit.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_op_sel,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_alu_req,
  output logic [XLEN-1:0] o_alu_op1,
  output logic [XLEN-1:0] o_alu_op2,
  output logic [3:0]      o_alu_func,
  input  logic [XLEN-1:0] i_alu_res
);

  mul_state_e      r_state, w_state_d;
  logic [XLEN-1:0] r_hi, w_hi_d;
  logic [XLEN-1:0] r_lo, w_lo_d;
  logic [XLEN-1:0] r_mcand, w_mcand_d;
  logic [XLEN-1:0] r_tmp, w_tmp_d;
  logic [XLEN-1:0] r_result, w_result_d;
  logic [4:0]      r_cnt, w_cnt_d;
  logic            r_opm, w_opm_d;
  logic            w_carry;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_tmp    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_opm    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_hi     <= w_hi_d;
      r_lo     <= w_lo_d;
      r_mcand  <= w_mcand_d;
      r_tmp    <= w_tmp_d;
      r_result <= w_result_d;
      r_cnt    <= w_cnt_d;
      r_opm    <= w_opm_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_hi_d     = r_hi;
    w_lo_d     = r_lo;
    w_mcand_d  = r_mcand;
    w_tmp_d    = r_tmp;
    w_result_d = r_result;
    w_cnt_d    = r_cnt;
    w_opm_d    = r_opm;
    w_carry    = 1'b0;
    o_alu_op1  = '0;
    o_alu_op2  = '0;
    o_alu_func = 4'b0000;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_opm_d = i_op_sel;
          w_hi_d  = '0;
          w_cnt_d = '0;
          if ((i_rs1 == '0) || (i_rs2 == '0)) begin
            // Zero operand: product is zero, skip the iteration entirely.
            w_lo_d     = '0;
            w_result_d = '0;
            w_state_d  = StDone;
          end else begin
            w_mcand_d = i_rs1;
            w_lo_d    = i_rs2;
            w_state_d = StAdd;
          end
        end
      end
      StAdd: begin
        o_alu_op1  = r_hi;
        o_alu_op2  = r_mcand;
        o_alu_func = AluFuncAdd;
        w_tmp_d    = r_lo[0] ? i_alu_res : r_hi;
        w_state_d  = StCarry;
      end
      StCarry: begin
        // A wrapped sum is smaller than the addend, so SLTU(sum, mcand) is the carry.
        o_alu_op1  = r_tmp;
        o_alu_op2  = r_mcand;
        o_alu_func = AluFuncSltu;
        w_carry    = r_lo[0] & i_alu_res[0];
        w_hi_d     = {w_carry, r_tmp[XLEN-1:1]};
        w_lo_d     = {r_tmp[0], r_lo[XLEN-1:1]};
        if (r_cnt == 5'd31) begin
          w_result_d = r_opm ? w_hi_d : w_lo_d;
          w_state_d  = StDone;
        end else begin
          w_cnt_d   = r_cnt + 5'd1;
          w_state_d = StAdd;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (i_flush) begin
      w_state_d  = StIdle;
      w_result_d = r_result;
    end
  end

  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StDone) && !i_flush;
  assign o_alu_req = (r_state == StAdd) || (r_state == StCarry);
  assign o_result  = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural EX ALU in the loop, directed and random
// multiplies checked against a 64-bit arithmetic product.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sel;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_func;
  logic [31:0] alu_res;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.XLEN(32)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op_sel   (op_sel),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_flush    (flush),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_alu_req  (alu_req),
    .o_alu_op1  (alu_op1),
    .o_alu_op2  (alu_op2),
    .o_alu_func (alu_func),
    .i_alu_res  (alu_res)
  );

  always_comb begin
    alu_res = '0;
    case (alu_func)
      AluFuncAdd:  alu_res = alu_op1 + alu_op2;
      AluFuncSltu: alu_res = {31'd0, (alu_op1 < alu_op2)};
      default:     alu_res = '0;
    endcase
  end

  function automatic logic [31:0] ref_mul(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return op ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called away from clock edges while the DUT is idle; returns at the idle
  // cycle following done.
  task automatic run_mul(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b);
    int   cyc;
    int   busy_low;
    logic seen_req;
    logic got_done;
    logic fast;
    fast     = (a == 32'd0) || (b == 32'd0);
    op_sel   = op;
    rs1      = a;
    rs2      = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rs1      = $urandom;
    rs2      = $urandom;
    cyc      = 0;
    busy_low = 0;
    seen_req = 1'b0;
    got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_low++;
      if (alu_req) seen_req = 1'b1;
      if (done) got_done = 1'b1;
    end
    check({tag, " done_cycle"}, cyc, fast ? 32'd1 : 32'd65);
    check({tag, " result"}, result, ref_mul(op, a, b));
    check({tag, " busy_gaps"}, busy_low, 32'd0);
    check({tag, " alu_req_seen"}, {31'd0, seen_req}, {31'd0, !fast});
    @(negedge clk);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, " idle_op1"}, alu_op1, 32'd0);
  endtask

  initial begin
    int          cyc;
    int          n_done;
    logic [31:0] prev;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;

    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    op_sel = 1'b0;
    rs1    = '0;
    rs2    = '0;

    // Reset state
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst alu_req", {31'd0, alu_req}, 32'd0);
    check("rst alu_ops", alu_op1 | alu_op2, 32'd0);
    check("rst alu_func", {28'd0, alu_func}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_mul("mul_3x5", OpSelMul, 32'd3, 32'd5);
    check("mul_3x5 exact", result, 32'h0000000F);
    run_mul("mulhu_ff", OpSelMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mulhu_ff exact", result, 32'hFFFFFFFE);
    run_mul("mul_ff", OpSelMul, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mul_ff exact", result, 32'h00000001);
    run_mul("mul_8000x2", OpSelMul, 32'h80000000, 32'd2);
    check("mul_8000x2 exact", result, 32'h00000000);
    run_mul("mulhu_8000x2", OpSelMulhu, 32'h80000000, 32'd2);
    check("mulhu_8000x2 exact", result, 32'h00000001);
    run_mul("mul_zero", OpSelMul, 32'd0, 32'h1234);

    // Flush in cycle 30, then restart in cycle 31
    run_mul("pre_flush", OpSelMul, 32'd9, 32'd11);
    prev   = result;
    op_sel = OpSelMul;
    rs1    = 32'h00012345;
    rs2    = 32'h00000777;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    @(negedge clk);
    check("add_op1", alu_op1, 32'd0);
    check("add_op2", alu_op2, 32'h00012345);
    check("add_func", {28'd0, alu_func}, {28'd0, AluFuncAdd});
    @(negedge clk);
    check("carry_op1", alu_op1, 32'h00012345);
    check("carry_func", {28'd0, alu_func}, {28'd0, AluFuncSltu});
    for (int i = 3; i <= 30; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush no_done", n_done, 32'd0);
    check("flush result", result, prev);
    run_mul("restart_7x6", OpSelMul, 32'd7, 32'd6);
    check("restart exact", result, 32'd42);

    // Asynchronous reset mid-operation
    op_sel = OpSelMulhu;
    rs1    = 32'hDEADBEEF;
    rs2    = 32'h01234567;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst busy", {31'd0, busy}, 32'd0);
    check("async_rst alu_req", {31'd0, alu_req}, 32'd0);
    check("async_rst done", {31'd0, done}, 32'd0);
    check("async_rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Start while busy is ignored
    op_sel = OpSelMul;
    rs1    = 32'd1000;
    rs2    = 32'd77;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    repeat (5) begin
      @(negedge clk);
      cyc++;
    end
    op_sel = OpSelMulhu;
    rs1    = 32'hFFFF0000;
    rs2    = 32'h0000FFFF;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    check("ignored_start cycle", cyc, 32'd65);
    check("ignored_start result", result, 32'd77000);
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("ignored_start quiet", n_done, 32'd0);

    // Random operands against the arithmetic product
    for (int i = 0; i < 16; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 1'($urandom_range(0, 1));
      if (i == 3) a = 32'd0;
      if (i == 7) b = 32'd0;
      if (i == 9) a = 32'hFFFFFFFF;
      run_mul($sformatf("rand%0d", i), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
